// File: rtl/nav_ctrl_if.sv
// Signal bundle between the maze solver, the sensors and the PID/motor path of nav_ctrl.
// The master modport belongs to whatever drives the commands and sensors; nav_ctrl uses slave.
interface nav_ctrl_if;
  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic        hdng_rdy;
  logic        at_hdng;
  logic        lft_opn;
  logic        rght_opn;
  logic        frwrd_opn;
  logic        mv_cmplt;
  logic        moving;
  logic        en_fusion;
  logic [10:0] frwrd_spd;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    input  mv_cmplt, moving, en_fusion, frwrd_spd
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    output mv_cmplt, moving, en_fusion, frwrd_spd
  );
endinterface

// File: rtl/nav_ctrl.sv
// nav_ctrl: turns solver heading/move pulses into a heading-settle wait or a ramped forward move.
// Define NAV_FAST_SIM_EN to quadruple the speed step for shorter simulations.
module nav_ctrl #(
  parameter logic [10:0] MAX_SPD = 11'h2A0,
  parameter logic [10:0] SPD_INC = 11'h018
) (
  input logic       clk,
  input logic       rst,
  nav_ctrl_if.slave nav
);

  typedef enum logic [2:0] {
    IDLE,
    HDNG,
    FRWRD,
    DEC_NORM,
    DEC_FAST
  } state_t;

`ifdef NAV_FAST_SIM_EN
  localparam logic [11:0] STEP = {1'b0, SPD_INC} << 2;
`else
  localparam logic [11:0] STEP = {1'b0, SPD_INC};
`endif
  localparam logic [11:0] STEP_FAST = STEP << 1;

  state_t      state_q, state_d;
  logic [10:0] spd_q, spd_d;
  logic        mv_cmplt_q, mv_cmplt_d;
  logic        moving_q, moving_d;
  logic        en_fusion_q, en_fusion_d;
  logic        lft_ff_q, rght_ff_q;
  logic        lft_rise, rght_rise;
  logic [11:0] acc_sum;

  // Speed floor: anything at or below the step lands exactly on zero.
  function automatic logic [10:0] dec_spd(input logic [10:0] s, input logic [11:0] d);
    return ({1'b0, s} <= d) ? 11'd0 : (s - d[10:0]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      spd_q       <= '0;
      mv_cmplt_q  <= 1'b0;
      moving_q    <= 1'b0;
      en_fusion_q <= 1'b0;
      lft_ff_q    <= 1'b1;
      rght_ff_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      spd_q       <= spd_d;
      mv_cmplt_q  <= mv_cmplt_d;
      moving_q    <= moving_d;
      en_fusion_q <= en_fusion_d;
      lft_ff_q    <= nav.lft_opn;
      rght_ff_q   <= nav.rght_opn;
    end
  end

  always_comb begin
    state_d     = state_q;
    spd_d       = spd_q;
    mv_cmplt_d  = 1'b0;
    lft_rise    = nav.lft_opn & ~lft_ff_q;
    rght_rise   = nav.rght_opn & ~rght_ff_q;
    acc_sum     = {1'b0, spd_q} + STEP;

    case (state_q)
      IDLE: begin
        if (nav.strt_hdng)    state_d = HDNG;
        else if (nav.strt_mv) state_d = FRWRD;
      end
      HDNG: begin
        if (nav.at_hdng) begin
          state_d    = IDLE;
          mv_cmplt_d = 1'b1;
        end
      end
      FRWRD: begin
        if (nav.hdng_rdy)
          spd_d = (acc_sum > {1'b0, MAX_SPD}) ? MAX_SPD : acc_sum[10:0];
        if (!nav.frwrd_opn)
          state_d = DEC_FAST;
        else if ((nav.stp_lft && lft_rise) || (nav.stp_rght && rght_rise))
          state_d = DEC_NORM;
      end
      DEC_NORM: begin
        if (spd_q == 11'd0) begin
          state_d    = IDLE;
          mv_cmplt_d = 1'b1;
        end else begin
          if (nav.hdng_rdy)   spd_d = dec_spd(spd_q, STEP);
          if (!nav.frwrd_opn) state_d = DEC_FAST;
        end
      end
      DEC_FAST: begin
        if (spd_q == 11'd0) begin
          state_d    = IDLE;
          mv_cmplt_d = 1'b1;
        end else if (nav.hdng_rdy) begin
          spd_d = dec_spd(spd_q, STEP_FAST);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    if (state_d == IDLE || state_d == HDNG) spd_d = '0;
    moving_d    = (state_d != IDLE);
    en_fusion_d = (state_d == FRWRD || state_d == DEC_NORM || state_d == DEC_FAST) &&
                  (spd_d > (MAX_SPD >> 1));
  end

  assign nav.frwrd_spd = spd_q;
  assign nav.mv_cmplt  = mv_cmplt_q;
  assign nav.moving    = moving_q;
  assign nav.en_fusion = en_fusion_q;

endmodule

// File: tb/tb_nav_ctrl.sv
// tb_nav_ctrl: directed scoreboard bench for nav_ctrl with default parameters.
// Expected outputs are queued as each step is driven and compared after the following clock edge.
module tb_nav_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nav_ctrl_if navIf ();

  nav_ctrl dut (
    .clk (clk),
    .rst (rst),
    .nav (navIf)
  );

  typedef struct packed {
    logic [10:0] spd;
    logic        moving;
    logic        enFusion;
    logic        mvCmplt;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic fus(input int s);
    return s > 'h150;
  endfunction

  task automatic applyStimulus(input logic sh, input logic sm, input logic sl, input logic sr,
                               input logic hr, input logic ah, input logic lo, input logic ro,
                               input logic fo);
    navIf.strt_hdng = sh;
    navIf.strt_mv   = sm;
    navIf.stp_lft   = sl;
    navIf.stp_rght  = sr;
    navIf.hdng_rdy  = hr;
    navIf.at_hdng   = ah;
    navIf.lft_opn   = lo;
    navIf.rght_opn  = ro;
    navIf.frwrd_opn = fo;
  endtask

  task automatic expectOut(input int spd, input logic mv, input logic enf, input logic cmp);
    exp_t e;
    e.spd      = spd[10:0];
    e.moving   = mv;
    e.enFusion = enf;
    e.mvCmplt  = cmp;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s scoreboard empty", tag);
      return;
    end
    e = expQ.pop_front();
    checks++;
    assert (navIf.frwrd_spd === e.spd) else begin
      failures++;
      $error("[TB] FAIL %s frwrd_spd observed=%0h expected=%0h", tag, navIf.frwrd_spd, e.spd);
    end
    checks++;
    assert (navIf.moving === e.moving) else begin
      failures++;
      $error("[TB] FAIL %s moving observed=%0b expected=%0b", tag, navIf.moving, e.moving);
    end
    checks++;
    assert (navIf.en_fusion === e.enFusion) else begin
      failures++;
      $error("[TB] FAIL %s en_fusion observed=%0b expected=%0b", tag, navIf.en_fusion, e.enFusion);
    end
    checks++;
    assert (navIf.mv_cmplt === e.mvCmplt) else begin
      failures++;
      $error("[TB] FAIL %s mv_cmplt observed=%0b expected=%0b", tag, navIf.mv_cmplt, e.mvCmplt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int spd, input logic mv, input logic enf,
                      input logic cmp);
    expectOut(spd, mv, enf, cmp);
    cycle();
    checkOutput(tag);
  endtask

  // Full-speed ramp from IDLE; a stray strt_hdng mid-move must be ignored.
  task automatic rampUp();
    int s;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("start_mv", 0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus((k == 3), 0, 0, 0, 1, 0, 0, 0, 1);
      s = (24 * k > 672) ? 672 : 24 * k;
      step("ramp", s, 1, fus(s), 0);
    end
  endtask

  initial begin
    int s;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    expectOut(0, 0, 0, 0);
    #12;
    checkOutput("reset");
    cycle();
    rst = 1'b0;
    step("idle", 0, 0, 0, 0);

    // Ramp to ceiling, then a left opening triggers a normal stop.
    rampUp();
    applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 1);
    step("stop_lft", 672, 1, 1, 0);
    for (int k = 1; k <= 28; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 1);
      s = 672 - 24 * k;
      step("dec_norm", s, 1, fus(s), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("norm_cmplt", 0, 0, 0, 1);
    step("norm_after", 0, 0, 0, 0);

    // Obstacle and left rise together: fast deceleration must win.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle2", 0, 0, 0, 0);
    rampUp();
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0);
    step("obstacle", 672, 1, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 0);
      s = 672 - 48 * k;
      step("dec_fast", s, 1, fus(s), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("fast_cmplt", 0, 0, 0, 1);

    // Both starts in the completion cycle: heading wins; hdng_rdy must not move speed.
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 1);
    step("hdng_start", 0, 1, 0, 0);
    for (int k = 0; k < 50; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
      step("hdng_wait", 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("hdng_cmplt", 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("hdng_after", 0, 0, 0, 0);

    // Blocked immediately after strt_mv: finishes from zero speed.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("mv_blocked", 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("fast_zero", 0, 1, 0, 0);
    step("zero_cmplt", 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("zero_after", 0, 0, 0, 0);

    // Asynchronous reset mid-move with an opening held through reset.
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 1);
    step("mv_pre_rst", 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 1);
      step("pre_rst", 24 * k, 1, 0, 0);
    end
    rst = 1'b1;
    expectOut(0, 0, 0, 0);
    #1;
    checkOutput("async_rst");
    cycle();
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step("post_rst", 0, 0, 0, 0);

    // Opening present since reset only stops after falling and rising again.
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 1);
    step("mv_lft", 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 1);
      step("lft_held", 24 * k, 1, 0, 0);
    end
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 1);
    step("lft_fall", 120, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 1);
    step("lft_rise", 144, 1, 0, 0);
    step("dec_norm2", 120, 1, 0, 0);
    step("dec_norm2", 96, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 1, 0, 0);
    step("upgrade", 72, 1, 0, 0);
    step("dec_fast2", 24, 1, 0, 0);
    step("dec_fast2", 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("cmplt2", 0, 0, 0, 1);
    step("after2", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
